// File: rtl/pc_unit_if.sv
// Control-side bundle for the program-counter unit: next-PC selection, RAS call/return
// requests, and the registered fetch address and status returned to the datapath.
interface pc_unit_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic             PCWre;
    logic [1:0]       PCSrc;
    logic [WIDTH-1:0] branch_offset;
    logic [25:0]      jump_target;
    logic [WIDTH-1:0] reg_target;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [CW-1:0]    ras_count;
    logic             ras_overflow;
    logic             ras_underflow;
    logic             misalign_err;

    modport master (
        output PCWre, PCSrc, branch_offset, jump_target, reg_target, push, pop,
        input  pc, pc_plus4, ras_count, ras_overflow, ras_underflow, misalign_err
    );

    modport slave (
        input  PCWre, PCSrc, branch_offset, jump_target, reg_target, push, pop,
        output pc, pc_plus4, ras_count, ras_overflow, ras_underflow, misalign_err
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with sequential/branch/jump/jump-register selection, stall hold,
// and a circular return-address stack with sticky overflow/underflow/misalign flags.
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     Reset,
    pc_unit_if.slave bus
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] SRC_SEQ = 2'b00;
    localparam logic [1:0] SRC_BR  = 2'b01;
    localparam logic [1:0] SRC_JMP = 2'b10;
    localparam logic [1:0] SRC_JR  = 2'b11;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]    r_top;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_misalign;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_branch_pc;
    logic [WIDTH-1:0] w_jump_pc;
    logic [WIDTH-1:0] w_jr_raw;
    logic [WIDTH-1:0] w_jr_pc;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_is_jr;
    logic             w_pop_hit;
    logic             w_pop_miss;
    logic             w_full;
    logic             w_jr_misaligned;
    logic             w_wr_en;
    logic [PW-1:0]    w_wr_idx;
    logic [PW-1:0]    w_top_nxt;
    logic [CW-1:0]    w_count_nxt;

    assign w_pc_plus4  = r_pc + WIDTH'(4);
    assign w_branch_pc = w_pc_plus4 + (bus.branch_offset << 2);
    assign w_jump_pc   = {w_pc_plus4[WIDTH-1:28], bus.jump_target, 2'b00};

    // A pop only counts as a return when it accompanies a jump-register select.
    assign w_is_jr    = (bus.PCSrc == SRC_JR);
    assign w_pop_hit  = w_is_jr && bus.pop && (r_count != '0);
    assign w_pop_miss = w_is_jr && bus.pop && (r_count == '0);
    assign w_full     = (r_count == CW'(RAS_DEPTH));

    assign w_jr_raw        = w_pop_hit ? r_ras[r_top] : bus.reg_target;
    assign w_jr_misaligned = |w_jr_raw[1:0];
    assign w_jr_pc         = {w_jr_raw[WIDTH-1:2], 2'b00};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        w_next_pc = w_pc_plus4;
        unique case (bus.PCSrc)
            SRC_SEQ: w_next_pc = w_pc_plus4;
            SRC_BR:  w_next_pc = w_branch_pc;
            SRC_JMP: w_next_pc = w_jump_pc;
            SRC_JR:  w_next_pc = w_jr_pc;
            default: w_next_pc = w_pc_plus4;
        endcase
    end

    // Push with a valid pop replaces the top in place; a plain push advances top,
    // which on a full stack lands on (and overwrites) the oldest entry.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_idx    = r_top;
        w_top_nxt   = r_top;
        w_count_nxt = r_count;
        if (bus.push && w_pop_hit) begin
            w_wr_en  = 1'b1;
            w_wr_idx = r_top;
        end else if (bus.push) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_top + PW'(1);
            w_top_nxt = r_top + PW'(1);
            if (!w_full) begin
                w_count_nxt = r_count + CW'(1);
            end
        end else if (w_pop_hit) begin
            w_top_nxt   = r_top - PW'(1);
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_pc        <= RESET_PC;
            r_top       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_misalign  <= 1'b0;
        end else if (bus.PCWre) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_pc        <= w_next_pc;
            r_top       <= w_top_nxt;
            r_count     <= w_count_nxt;
            r_overflow  <= r_overflow | (bus.push && !w_pop_hit && w_full);
            r_underflow <= r_underflow | w_pop_miss;
            r_misalign  <= r_misalign | (w_is_jr && w_jr_misaligned);
        end
    end

    // NOTE: stack storage is not reset; r_count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (!Reset && bus.PCWre && w_wr_en) begin
            r_ras[w_wr_idx] <= w_pc_plus4;
        end
    end

    assign bus.pc            = r_pc;
    assign bus.pc_plus4      = w_pc_plus4;
    assign bus.ras_count     = r_count;
    assign bus.ras_overflow  = r_overflow;
    assign bus.ras_underflow = r_underflow;
    assign bus.misalign_err  = r_misalign;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expected addresses.
module tb_pc_unit;
    localparam int unsigned      WIDTH     = 32;
    localparam int unsigned      RAS_DEPTH = 4;
    localparam logic [31:0]      RESET_PC  = 32'h0040_0000;

    logic clk;
    logic Reset;

    pc_unit_if #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) bus ();

    pc_unit #(.WIDTH(WIDTH), .RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras [$];
    logic        m_ovf;
    logic        m_unf;
    logic        m_mis;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_mis = 1'b0;
    endtask

    // Reference behaviour: the stack is a list of return addresses, newest last,
    // holding at most RAS_DEPTH entries (oldest dropped on overflow).
    task automatic model_step();
        logic [31:0] p4;
        logic [31:0] nxt;
        logic [31:0] sel;
        bit          is_ret;
        p4     = m_pc + 32'd4;
        is_ret = (bus.PCSrc == 2'd3) && bus.pop;
        nxt    = p4;
        case (bus.PCSrc)
            2'd0: nxt = p4;
            2'd1: nxt = p4 + (bus.branch_offset * 4);
            2'd2: nxt = {p4[31:28], bus.jump_target, 2'b00};
            default: begin
                if (is_ret && m_ras.size() > 0) sel = m_ras[$];
                else sel = bus.reg_target;
                if (is_ret && m_ras.size() == 0) m_unf = 1'b1;
                if (sel % 4 != 0) begin
                    m_mis = 1'b1;
                    sel   = sel - (sel % 4);
                end
                nxt = sel;
            end
        endcase
        if (is_ret && m_ras.size() > 0) void'(m_ras.pop_back());
        if (bus.push) begin
            if (m_ras.size() == RAS_DEPTH) begin
                void'(m_ras.pop_front());
                m_ovf = 1'b1;
            end
            m_ras.push_back(p4);
        end
        m_pc = nxt;
    endtask

    always @(posedge clk) begin
        if (!Reset && bus.PCWre) model_step();
    end

    always @(posedge Reset) model_reset();

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_pc", bus.pc, m_pc);
            check("cyc_pc_plus4", bus.pc_plus4, m_pc + 32'd4);
            check("cyc_ras_count", bus.ras_count, m_ras.size());
            check("cyc_overflow", bus.ras_overflow, m_ovf);
            check("cyc_underflow", bus.ras_underflow, m_unf);
            check("cyc_misalign", bus.misalign_err, m_mis);
        end
    end

    task automatic tick(input logic we, input logic [1:0] src, input logic ps, input logic pp,
                        input logic [31:0] rt, input logic [31:0] bo, input logic [25:0] jt);
        bus.PCWre         = we;
        bus.PCSrc         = src;
        bus.push          = ps;
        bus.pop           = pp;
        bus.reg_target    = rt;
        bus.branch_offset = bo;
        bus.jump_target   = jt;
        @(posedge clk);
        #1;
    endtask

    task automatic jr(input logic [31:0] target);
        tick(1'b1, 2'd3, 1'b0, 1'b0, target, 32'd0, 26'd0);
    endtask

    task automatic pulse_reset();
        #2;
        Reset = 1'b1;
        #1;
        check("async_reset_pc", bus.pc, RESET_PC);
        check("async_reset_count", bus.ras_count, 0);
        check("async_reset_flags", {bus.ras_overflow, bus.ras_underflow, bus.misalign_err}, 0);
        #2;
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] calls [5];
        logic [31:0] rets  [4];
        calls = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 32'h0000_5000};
        rets  = '{32'h0000_4004, 32'h0000_3004, 32'h0000_2004, 32'h0000_1004};

        Reset = 1'b1;
        bus.PCWre = 1'b0;
        bus.PCSrc = 2'd0;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.reg_target = '0;
        bus.branch_offset = '0;
        bus.jump_target = '0;
        model_reset();
        #12;
        check("reset_pc", bus.pc, 32'h0040_0000);
        check("reset_pc_plus4", bus.pc_plus4, 32'h0040_0004);
        check("reset_count", bus.ras_count, 0);
        check("reset_flags", {bus.ras_overflow, bus.ras_underflow, bus.misalign_err}, 0);
        chk_en = 1'b1;
        Reset = 1'b0;

        tick(1'b1, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
        check("seq_1", bus.pc, 32'h0040_0004);
        tick(1'b1, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
        check("seq_2", bus.pc, 32'h0040_0008);
        tick(1'b1, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0, 26'd0);
        check("seq_3", bus.pc, 32'h0040_000C);
        pulse_reset();

        jr(32'h0000_0100);
        check("jr_0x100", bus.pc, 32'h0000_0100);
        tick(1'b1, 2'd1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFE, 26'd0);
        check("branch_neg2", bus.pc, 32'h0000_00FC);
        jr(32'h1000_0000);
        tick(1'b1, 2'd2, 1'b0, 1'b0, 32'd0, 32'd0, 26'h000_0010);
        check("jump_region", bus.pc, 32'h1000_0040);

        tick(1'b0, 2'd1, 1'b1, 1'b0, 32'd0, 32'd8, 26'd0);
        tick(1'b0, 2'd1, 1'b1, 1'b0, 32'd0, 32'd8, 26'd0);
        check("stall_pc", bus.pc, 32'h1000_0040);
        check("stall_pc_plus4", bus.pc_plus4, 32'h1000_0044);
        check("stall_count", bus.ras_count, 0);

        jr(32'h0000_0200);
        tick(1'b1, 2'd3, 1'b1, 1'b0, 32'h0000_0300, 32'd0, 26'd0);
        tick(1'b1, 2'd0, 1'b1, 1'b0, 32'd0, 32'd0, 26'd0);
        check("call2_count", bus.ras_count, 2);
        tick(1'b1, 2'd3, 1'b0, 1'b1, 32'd0, 32'd0, 26'd0);
        check("ret1_pc", bus.pc, 32'h0000_0304);
        check("ret1_count", bus.ras_count, 1);
        tick(1'b1, 2'd3, 1'b0, 1'b1, 32'd0, 32'd0, 26'd0);
        check("ret2_pc", bus.pc, 32'h0000_0204);
        check("ret2_count", bus.ras_count, 0);
        tick(1'b1, 2'd3, 1'b0, 1'b1, 32'h0000_0500, 32'd0, 26'd0);
        check("ret_empty_pc", bus.pc, 32'h0000_0500);
        check("ret_empty_underflow", bus.ras_underflow, 1);

        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 2'd3, 1'b1, 1'b0, calls[i], 32'd0, 26'd0);
        end
        check("ovf_count", bus.ras_count, 4);
        check("ovf_flag", bus.ras_overflow, 1);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 2'd3, 1'b0, 1'b1, 32'd0, 32'd0, 26'd0);
            check($sformatf("ovf_ret_%0d", i), bus.pc, rets[i]);
        end
        check("ovf_drained", bus.ras_count, 0);

        jr(32'h0000_0400);
        tick(1'b1, 2'd3, 1'b1, 1'b0, 32'h0000_0600, 32'd0, 26'd0);
        check("pp_setup_count", bus.ras_count, 1);
        tick(1'b1, 2'd3, 1'b1, 1'b1, 32'd0, 32'd0, 26'd0);
        check("pushpop_pc", bus.pc, 32'h0000_0404);
        check("pushpop_count", bus.ras_count, 1);
        tick(1'b1, 2'd3, 1'b0, 1'b1, 32'd0, 32'd0, 26'd0);
        check("pushpop_newtop", bus.pc, 32'h0000_0604);
        jr(32'h0000_0703);
        check("misalign_pc", bus.pc, 32'h0000_0700);
        check("misalign_flag", bus.misalign_err, 1);

        pulse_reset();
        tick(1'b1, 2'd0, 1'b0, 1'b1, 32'd0, 32'd0, 26'd0);
        check("pop_ignored_pc", bus.pc, 32'h0040_0004);
        check("pop_ignored_underflow", bus.ras_underflow, 0);
        tick(1'b1, 2'd3, 1'b1, 1'b1, 32'h0000_0800, 32'd0, 26'd0);
        check("pushpop_empty_pc", bus.pc, 32'h0000_0800);
        check("pushpop_empty_count", bus.ras_count, 1);
        check("pushpop_empty_underflow", bus.ras_underflow, 1);
        tick(1'b1, 2'd3, 1'b0, 1'b1, 32'd0, 32'd0, 26'd0);
        check("pushpop_empty_ret", bus.pc, 32'h0040_0008);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle MIPS datapath; successor to the fixed 32-bit PC register. It holds the fetch address and selects the next address from sequential, branch, jump and jump-register sources. It adds a RESET_PC reset vector, a stall hold, and a parametrised return-address stack (RAS) for call/return, with sticky error flags. It sits between the control unit (select/enable) and instruction memory (address).

## Interface
Parameters:
- WIDTH, 32, PC width in bits; legal range 29..64.
- RESET_PC, 0, value loaded into pc on reset; must be word-aligned.
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PCWre  in  1  update enable; 0 holds pc, RAS and flags.
- PCSrc  in  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 jump-register.
- branch_offset  in  WIDTH  sign-extended word offset.
- jump_target  in  26  J-format instruction index.
- reg_target  in  WIDTH  register jump address.
- push  in  1  call: push pc_plus4 onto RAS.
- pop  in  1  return: with PCSrc=11, take target from RAS top.
- pc  out  WIDTH  current fetch address (registered).
- pc_plus4  out  WIDTH  pc+4 (combinational).
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries (registered).
- ras_overflow  out  1  sticky: push while full.
- ras_underflow  out  1  sticky: pop while empty.
- misalign_err  out  1  sticky: register target with nonzero [1:0].

## Operation
- pc_plus4 = pc + 4, mod 2^WIDTH.
- Next PC:
  - 00 → pc_plus4.
  - 01 → pc_plus4 + (branch_offset << 2), mod 2^WIDTH; overflow discarded.
  - 10 → {pc_plus4[WIDTH-1:28], jump_target, 2'b00}.
  - 11, pop=0 → reg_target.
  - 11, pop=1, count>0 → RAS top.
  - 11, pop=1, count=0 → reg_target; set ras_underflow.
- Jump-register alignment: if the selected address (reg_target or RAS top) has [1:0]≠0, bits [1:0] are forced to 0 and misalign_err is set.
- pop with PCSrc≠11 is ignored: no RAS change, no flag.
- RAS is a circular buffer with a top pointer.
  - Push, not full: write pc_plus4 above top; count+1.
  - Push, full: overwrite the oldest entry; top advances; count stays RAS_DEPTH; set ras_overflow.
  - Valid pop, count>0: count−1.
  - Simultaneous valid pop and push: next PC = old top; top entry is replaced by pc_plus4; count unchanged; no flag.
  - Simultaneous push with pop on empty RAS: push proceeds (count becomes 1); ras_underflow is set.
- Sticky flags clear only on Reset.
- PCWre=0: every input is ignored, including push and pop. Outputs hold except pc_plus4, which tracks the held pc.

## Timing
- Reset asserted: asynchronously, pc=RESET_PC, ras_count=0, all flags=0, top pointer=0. RAS contents are don't-care.
- Reset deasserted: the first update occurs at the next rising edge with PCWre=1.
- Reset mid-operation: any pending push or pop in that cycle is discarded.
- Latency: the next-PC selection is registered at the rising edge and visible on pc one cycle later. The RAS, ras_count and flags update on that same edge.
- No combinational path exists from push, pop or PCSrc to pc, ras_count or the flags.

## Test plan
- Reset/sequential: RESET_PC=0x00400000; release Reset, PCSrc=00 for 3 edges → pc 0x00400004, 0x00400008, 0x0040000C. Assert Reset mid-cycle → pc=0x00400000 immediately, before the next edge.
- Branch/jump: pc=0x100, PCSrc=01, branch_offset=−2 → pc=0x0FC. Then pc=0x10000000, PCSrc=10, jump_target=0x0000010 → pc=0x10000040.
- Stall: PCWre=0 for 2 edges with push=1 and PCSrc=01 → pc and ras_count unchanged; pc_plus4 stable.
- RAS call/return: push at pc=0x200 then at pc=0x300 → count=2. PCSrc=11, pop=1 → pc=0x304, count=1. Repeat the pop → pc=0x204, count=0. Pop again with reg_target=0x500 → pc=0x500, ras_underflow=1.
- Overflow wrap: RAS_DEPTH=4; push 5 times at distinct pcs A..E → count=4, ras_overflow=1. Pop 4 times → returns E+4, D+4, C+4, B+4 (A+4 was overwritten).
- Push+pop / misalign: top=0x404 and push at pc=0x600 with PCSrc=11, pop=1 → pc=0x404, count unchanged, new top=0x604. Then reg_target=0x703, pop=0 → pc=0x700, misalign_err=1.
